// File: rtl/regarb_pkg.sv
// Shared types and sizing helpers for the register write arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package regarb_pkg;

  // Arbiter controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_W     = 8;

  // Index width for a requester count; never below 1 bit
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Round-robin winner select: first active request strictly after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  // Scan ptr+1 .. ptr+N_REQ (mod N_REQ); the first hit wins
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!valid && req[(int'(ptr) + k) % N_REQ]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write controller driving a shared clearable register bank.
// Latency: req seen in IDLE -> reg_d in cycle 1, gnt in cycle 2; 3 cycles/write (2 when locked).
// Backpressure: requesters hold req/wdata until gnt; only IDLE samples req and clr_req.
// Optional build macro: REGARB_LOCK_EN (back-to-back ownership for the current winner).
module reg_write_arbiter
  import regarb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W
) (
  input  logic               clk,
  input  logic               Rn,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] wdata,
  input  logic [N_REQ-1:0]   lock,
  input  logic               clr_req,
  input  logic [W-1:0]       reg_q,
  output logic [W-1:0]       reg_d,
  output logic               reg_clear,
  output logic [N_REQ-1:0]   gnt,
  output logic               clr_ack,
  output logic               busy
);

  localparam int IW = idx_w(N_REQ);

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   win, win_nxt;
  logic [W-1:0]    hold, hold_nxt;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic            lock_go;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

`ifdef REGARB_LOCK_EN
  // Winner keeps ownership while it holds lock and req, unless a clear is waiting
  assign lock_go = lock[win] & req[win] & ~clr_req;
`else
  logic unused_lock;
  assign lock_go     = 1'b0;
  assign unused_lock = ^lock;
`endif

  // Next-state and datapath-load decisions
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    win_nxt   = win;
    hold_nxt  = hold;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
        end else if (pick_vld) begin
          state_nxt = WRITE;
          win_nxt   = pick_idx;
          hold_nxt  = wdata[int'(pick_idx)*W +: W];
        end
      end
      WRITE: state_nxt = ACK;
      ACK: begin
        ptr_nxt = win;
        if (lock_go) begin
          state_nxt = WRITE;
          hold_nxt  = wdata[int'(win)*W +: W];
        end else begin
          state_nxt = IDLE;
        end
      end
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!Rn) begin
      state <= IDLE;
      ptr   <= IW'(N_REQ - 1);
      win   <= '0;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      win   <= win_nxt;
      hold  <= hold_nxt;
    end
  end

  // Outputs are pure decodes of registered state; register recirculates outside WRITE
  always_comb begin
    reg_d     = reg_q;
    gnt       = '0;
    reg_clear = 1'b0;
    clr_ack   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      WRITE: reg_d = hold;
      ACK:   gnt   = N_REQ'(1) << win;
      CLEAR: begin
        reg_clear = 1'b1;
        clr_ack   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter with a behavioural clearable register bank.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// Expected values come from a round-robin model and a tracked register value.
module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         Rn;
  logic [N-1:0] req;
  logic [N*W-1:0] wdata;
  logic [N-1:0] lock;
  logic         clr_req;
  logic [W-1:0] reg_q;
  logic [W-1:0] reg_d;
  logic         reg_clear;
  logic [N-1:0] gnt;
  logic         clr_ack;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int mptr;            // model round-robin pointer
  logic [W-1:0] mq;    // model register contents

  reg_write_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .Rn        (Rn),
    .req       (req),
    .wdata     (wdata),
    .lock      (lock),
    .clr_req   (clr_req),
    .reg_q     (reg_q),
    .reg_d     (reg_d),
    .reg_clear (reg_clear),
    .gnt       (gnt),
    .clr_ack   (clr_ack),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank: D flip-flop with asynchronous active-high clear
  always @(posedge clk or posedge reg_clear) begin
    if (reg_clear) reg_q <= '0;
    else           reg_q <= reg_d;
  end

  // Round-robin rule: lowest active index above p, otherwise lowest active index overall
  function automatic int rr_model(input logic [N-1:0] r, input int p);
    for (int i = p + 1; i < N; i++) if (r[i]) return i;
    for (int i = 0; i <= p; i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] d);
    wdata[i*W +: W] = d;
  endtask

  task automatic do_reset();
    Rn = 1'b0;
    tick();
    tick();
    Rn = 1'b1;
    mptr = N - 1;
  endtask

  // Plain write of one requester, leaves the DUT in IDLE
  task automatic do_write(input int i, input logic [W-1:0] d);
    req = onehot(i);
    set_data(i, d);
    tick();
    tick();
    req = '0;
    tick();
    mptr = i;
    mq = d;
  endtask

  task automatic test_reset();
    req = '0; wdata = '0; lock = '0; clr_req = 1'b0;
    do_reset();
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (clr_ack !== 1'b0) begin errors++; $display("FAIL reset_clr_ack: got %b want 0", clr_ack); end
    checks++; if (reg_clear !== 1'b0) begin errors++; $display("FAIL reset_reg_clear: got %b want 0", reg_clear); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    req = 4'b0001;
    set_data(0, 8'hA5);
    tick();
    checks++; if (reg_d !== 8'hA5) begin errors++; $display("FAIL single_reg_d: got %h want a5", reg_d); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_early_gnt: got %b want 0000", gnt); end
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    checks++; if (reg_q !== 8'hA5) begin errors++; $display("FAIL single_reg_q: got %h want a5", reg_q); end
    req = '0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
    mptr = 0;
    mq = 8'hA5;
  endtask

  task automatic test_fairness();
    logic [N-1:0] eg;
    int w;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_data(i, W'(8'h11 * (i + 1)));
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k % 3 == 2) begin
        w = rr_model(req, mptr);
        eg = onehot(w);
        mptr = w;
        mq = wdata[w*W +: W];
        checks++; if (gnt !== eg) begin errors++; $display("FAIL fair_gnt k=%0d: got %b want %b", k, gnt, eg); end
        checks++; if (reg_q !== mq) begin errors++; $display("FAIL fair_reg_q k=%0d: got %h want %h", k, reg_q, mq); end
      end else begin
        checks++; if (gnt !== '0) begin errors++; $display("FAIL fair_idle_gnt k=%0d: got %b want 0000", k, gnt); end
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_clear_then_write();
    do_write(3, 8'h5A);
    checks++; if (reg_q !== 8'h5A) begin errors++; $display("FAIL clr_pre_q: got %h want 5a", reg_q); end
    clr_req = 1'b1;
    req = 4'b0100;
    set_data(2, 8'h77);
    tick();
    checks++; if (reg_clear !== 1'b1 || clr_ack !== 1'b1) begin errors++; $display("FAIL clr_pulse: got clear=%b ack=%b want 1 1", reg_clear, clr_ack); end
    checks++; if (reg_q !== 8'h00) begin errors++; $display("FAIL clr_reg_q: got %h want 00", reg_q); end
    clr_req = 1'b0;
    tick();
    checks++; if (reg_clear !== 1'b0 || clr_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clr_one_cycle: got clear=%b ack=%b busy=%b want 0 0 0", reg_clear, clr_ack, busy); end
    tick();
    checks++; if (reg_d !== 8'h77) begin errors++; $display("FAIL clr_write_d: got %h want 77", reg_d); end
    tick();
    checks++; if (gnt !== 4'b0100 || reg_q !== 8'h77) begin errors++; $display("FAIL clr_write_gnt: got gnt=%b q=%h want 0100 77", gnt, reg_q); end
    req = '0;
    tick();
    mptr = 2;
    mq = 8'h77;
  endtask

  task automatic test_reset_during_write();
    req = 4'b0010;
    set_data(1, 8'h3C);
    tick();
    checks++; if (reg_d !== 8'h3C) begin errors++; $display("FAIL rstw_reg_d: got %h want 3c", reg_d); end
    Rn = 1'b0;
    tick();
    Rn = 1'b1;
    checks++; if (reg_q !== 8'h3C) begin errors++; $display("FAIL rstw_reg_q: got %h want 3c", reg_q); end
    checks++; if (gnt !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rstw_state: got gnt=%b busy=%b want 0000 0", gnt, busy); end
    mptr = N - 1;
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_data(i, W'(8'hC0 + i));
    tick();
    tick();
    checks++; if (gnt !== onehot(rr_model(4'b1111, mptr))) begin errors++; $display("FAIL rstw_ptr: got %b want %b", gnt, onehot(rr_model(4'b1111, mptr))); end
    req = '0;
    tick();
    mptr = 0;
    mq = 8'hC0;
  endtask

  task automatic test_idle_hold();
    do_write(0, 8'h99);
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (reg_d !== 8'h99 || reg_q !== 8'h99 || gnt !== '0 || reg_clear !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold k=%0d: got d=%h q=%h gnt=%b clr=%b busy=%b want 99 99 0000 0 0", k, reg_d, reg_q, gnt, reg_clear, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [W-1:0] ed;
    logic         c;
    int           w;
    for (int t = 0; t < 25; t++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      c = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) set_data(i, W'($urandom));
      w = rr_model(r, mptr);
      ed = wdata[w*W +: W];
      req = r;
      clr_req = c;
      tick();
      if (c) begin
        mq = '0;
        checks++; if (reg_clear !== 1'b1 || reg_q !== mq) begin errors++; $display("FAIL rnd_clear t=%0d: got clr=%b q=%h want 1 %h", t, reg_clear, reg_q, mq); end
        clr_req = 1'b0;
        tick();
        tick();
      end
      // Data changes after the sampling cycle must not reach the register
      for (int i = 0; i < N; i++) set_data(i, W'($urandom));
      checks++; if (reg_d !== ed) begin errors++; $display("FAIL rnd_reg_d t=%0d: got %h want %h", t, reg_d, ed); end
      tick();
      mptr = w;
      mq = ed;
      checks++; if (gnt !== onehot(w) || reg_q !== mq) begin errors++; $display("FAIL rnd_gnt t=%0d: got gnt=%b q=%h want %b %h", t, gnt, reg_q, onehot(w), mq); end
      req = '0;
      tick();
      checks++; if (busy !== 1'b0 || reg_d !== mq) begin errors++; $display("FAIL rnd_idle t=%0d: got busy=%b d=%h want 0 %h", t, busy, reg_d, mq); end
    end
  endtask

`ifdef REGARB_LOCK_EN
  task automatic test_lock();
    lock = 4'b0010;
    req = 4'b0010;
    set_data(1, 8'h01);
    set_data(0, 8'hEE);
    tick();
    tick();
    checks++; if (gnt !== 4'b0010 || reg_q !== 8'h01) begin errors++; $display("FAIL lock_first: got gnt=%b q=%h want 0010 01", gnt, reg_q); end
    req = 4'b0011;
    for (int s = 2; s <= 3; s++) begin
      set_data(1, W'(s));
      tick();
      checks++; if (reg_d !== W'(s)) begin errors++; $display("FAIL lock_d s=%0d: got %h want %h", s, reg_d, W'(s)); end
      tick();
      checks++; if (gnt !== 4'b0010 || reg_q !== W'(s)) begin errors++; $display("FAIL lock_gnt s=%0d: got gnt=%b q=%h want 0010 %h", s, gnt, reg_q, W'(s)); end
    end
    clr_req = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_break: got busy=%b want 0", busy); end
    tick();
    checks++; if (reg_clear !== 1'b1) begin errors++; $display("FAIL lock_clear: got %b want 1", reg_clear); end
    clr_req = 1'b0;
    req = '0;
    lock = '0;
    tick();
    mptr = 1;
    mq = '0;
  endtask
`endif

  initial begin
    Rn = 1'b1;
    req = '0;
    wdata = '0;
    lock = '0;
    clr_req = 1'b0;
    mptr = N - 1;
    mq = '0;
    test_reset();
    test_single();
    test_fairness();
    test_clear_then_write();
    test_reset_during_write();
    test_idle_hold();
    test_random();
`ifdef REGARB_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write controller for the shared 8-bit clearable register bank (D flip-flop register, clock `clk`, active-high `clear`). Up to `N_REQ` requesters compete for write access. The block serialises their writes and drives the register's D input and clear line, then acknowledges each requester once its data is in the register. When no write is in progress it recirculates the register output, so the value is held.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `W`, 8: data width; matches the register bank.
- `clk` in 1: rising-edge clock, shared with the register bank.
- `Rn` in 1: synchronous, active-low reset.
- `req` in N_REQ: write request per requester; level-held until granted.
- `wdata` in N_REQ*W: requester i's data in bits [i*W +: W].
- `lock` in N_REQ: back-to-back ownership request (used only with `REGARB_LOCK_EN`).
- `clr_req` in 1: request to clear the register.
- `reg_q` in W: register bank Q output.
- `reg_d` out W: register bank D input.
- `reg_clear` out 1: register bank `clear`, active high.
- `gnt` out N_REQ: one-hot write-done acknowledge, pulsed one cycle.
- `clr_ack` out 1: one-cycle clear-done pulse.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, WRITE, ACK, CLEAR.
- IDLE:
  - If `clr_req` is high, go to CLEAR. Clear has priority over all writes.
  - Else if `|req`, pick a winner by round-robin. The search starts at `ptr+1` and wraps modulo N_REQ. Latch the winner index into `win` and its `wdata` slice into `hold`, then go to WRITE.
- WRITE: `reg_d = hold`; the register captures it at the end of this cycle. Next state is ACK.
- ACK: `gnt[win]=1`, `ptr <= win`. Next state is IDLE (lock exception under Configuration).
- CLEAR: `reg_clear=1` and `clr_ack=1` for exactly one cycle. Next state is IDLE. `ptr` is unchanged.
- `reg_d = reg_q` in every state except WRITE (hold by recirculation).
- Requester rule: keep `req` and `wdata` stable until `gnt` is seen.
  - `req` still high in the cycle after `gnt` counts as a new request.
  - Changing `wdata` after the IDLE sampling cycle has no effect.
- Requests arriving during WRITE, ACK or CLEAR wait. Only IDLE samples `req` and `clr_req`.
- `clr_req` arriving mid-write waits until the write is acknowledged.
- Fairness: N_REQ requesters held continuously each receive exactly one grant per N_REQ transactions.

## Timing
- Reset (`Rn` low at a rising edge) sets:
  - state = IDLE, `ptr = N_REQ-1` (requester 0 has first priority), `win = 0`, `hold = 0`
  - `gnt = 0`, `clr_ack = 0`, `reg_clear = 0`, `busy = 0`
- Register contents are not cleared by reset.
- Reset during WRITE: the register still captures `hold` on that edge (synchronous reset). No `gnt` is issued, and the requester must keep `req` high to retry.
- Reset during ACK: the pending `gnt` is dropped.
- Write latency, with `req` first seen in IDLE at cycle 0:
  - cycle 1: WRITE, `reg_d = data`
  - cycle 2: ACK, `reg_q = data`, `gnt` high
  - cycle 3: IDLE
- Throughput is one write per 3 cycles.
- Clear: `clr_req` seen in IDLE at cycle 0 gives `reg_clear` high in cycle 1. `reg_q = 0` from cycle 1 (asynchronous clear).
- `clr_req` and `req` in the same IDLE cycle: CLEAR runs first, and the write follows after returning to IDLE.
- All outputs are registered-state decodes. There is no combinational path from `req` to `gnt`.

## Configuration
- `REGARB_LOCK_EN` defined:
  - In ACK, if `lock[win] && req[win]`, relatch `hold` from `wdata[win]` and go directly to WRITE, skipping IDLE and arbitration. This gives 2 cycles per write.
  - `clr_req` pending in ACK breaks the lock and goes to IDLE.
  - `ptr` still updates to `win`.
- `REGARB_LOCK_EN` undefined: the `lock` port exists but is ignored, and ACK always goes to IDLE.

## Structure
- Shared package `regarb_pkg`: state enum (IDLE, WRITE, ACK, CLEAR), default widths, and index-width function `$clog2(N_REQ)`.
- Sub-module `rr_pick`: combinational round-robin winner select.
  - Inputs: `req`, `ptr`.
  - Outputs: `valid`, `idx`.
- The top level holds the FSM, `win`, `hold` and `ptr`, and instantiates the register bank in the bench only.

## Test plan
- Reset, then `req=4'b0001`, `wdata0=8'hA5`: `reg_d=A5` in cycle 1, `gnt=0001` and `reg_q=A5` in cycle 2, `busy` low in cycle 3.
- `req=4'b1111` held, data 11/22/33/44: grants arrive in order 0,1,2,3,0 and `reg_q` follows 11,22,33,44,11, one grant every 3 cycles.
- `reg_q=5A`, then `clr_req` and `req[2]` (data 77) in the same cycle: `reg_clear` and `clr_ack` pulse in cycle 1 and `reg_q=00`. The write of 77 is then granted with `gnt=0100`.
- `Rn` low during WRITE with `hold=3C`: `reg_q=3C`, no `gnt`, state IDLE and `ptr=N_REQ-1` after the edge.
- With `REGARB_LOCK_EN`, `lock[1]=req[1]=1`, data stepping 01,02,03: writes arrive every 2 cycles with no interleaving of `req[0]`. Asserting `clr_req` ends the lock after the current ACK.
- Idle for 10 cycles with `reg_q=99`: `reg_d=99` throughout, and `gnt`, `reg_clear` and `busy` stay 0.
